// File: rtl/csa_operand_collector.sv
// Operand collector for the 3-input carry-save adder: gathers operands into
// zero-padded triples, presents them to the adder and returns the registered total.
module csa_operand_collector #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic               in_last,
   output logic [WIDTH-1:0]   op_a,
   output logic [WIDTH-1:0]   op_b,
   output logic [WIDTH-1:0]   op_c,
   input  logic [WIDTH+1:0]   csa_out,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [WIDTH+1:0]   res_data,
   output logic               res_last,
   output logic [CNT_W-1:0]   res_cnt
);

   // state   | meaning
   // COLLECT | accepting operands into slots a/b/c
   // CALC    | operands settled at the adder, capture total next edge
   // RESULT  | holding total until downstream accepts it
   localparam logic [1:0] COLLECT = 2'd0;
   localparam logic [1:0] CALC    = 2'd1;
   localparam logic [1:0] RESULT  = 2'd2;

   logic [1:0] state;
   logic [1:0] slot;
   logic       last_q;

   assign in_ready = (state == COLLECT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= COLLECT;
         slot      <= 2'd0;
         last_q    <= 1'b0;
         op_a      <= '0;
         op_b      <= '0;
         op_c      <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_last  <= 1'b0;
         res_cnt   <= '0;
      end else begin
         case (state)
            COLLECT: begin
               if (in_valid) begin
                  case (slot)
                     2'd0:    op_a <= in_data;
                     2'd1:    op_b <= in_data;
                     default: op_c <= in_data;
                  endcase
                  slot   <= slot + 2'd1;
                  last_q <= in_last;
                  if (slot == 2'd2 || in_last)
                     state <= CALC;
               end
            end
            CALC: begin
               res_data  <= csa_out;
               res_last  <= last_q;
               res_valid <= 1'b1;
               state     <= RESULT;
            end
            RESULT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  res_cnt   <= res_cnt + CNT_W'(1);
                  // clearing operands here is what zero-pads the next short group
                  op_a      <= '0;
                  op_b      <= '0;
                  op_c      <= '0;
                  slot      <= 2'd0;
                  last_q    <= 1'b0;
                  state     <= COLLECT;
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_csa_operand_collector.sv
// Bench for csa_operand_collector: behavioural adder on csa_out, result
// scoreboard fed at stimulus time and drained by a handshake monitor.
module tb_csa_operand_collector;

   localparam int WIDTH = 4;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_last = 1'b0;
   logic [WIDTH-1:0] op_a, op_b, op_c;
   logic [WIDTH+1:0] csa_out;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic [WIDTH+1:0] res_data;
   logic             res_last;
   logic [CNT_W-1:0] res_cnt;

   typedef struct packed {
      logic [WIDTH+1:0] sum;
      logic             last;
   } exp_t;

   exp_t             sb[$];
   logic [CNT_W-1:0] exp_cnt = '0;
   int               checks = 0;
   int               failures = 0;

   always #5 clk = ~clk;

   assign csa_out = (WIDTH+2)'(op_a) + (WIDTH+2)'(op_b) + (WIDTH+2)'(op_c);

   csa_operand_collector #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .op_a(op_a), .op_b(op_b), .op_c(op_c), .csa_out(csa_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_last(res_last), .res_cnt(res_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; an accept happens on the next rising edge.
   task automatic send(input logic [WIDTH-1:0] d, input logic l);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check_eq("in_ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_triple(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic [WIDTH-1:0] c);
      exp_t e;
      e.sum  = (WIDTH+2)'(a) + (WIDTH+2)'(b) + (WIDTH+2)'(c);
      e.last = 1'b0;
      sb.push_back(e);
      send(a, 1'b0);
      send(b, 1'b0);
      send(c, 1'b0);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq("drain", sb.size(), 32'd0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Handshake monitor: a result is compared on the cycle it will be accepted.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) begin
            exp_cnt = '0;
            sb.delete();
         end else if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
               check_eq("unexpected_result", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check_eq("res_data", 32'(res_data), 32'(e.sum));
               check_eq("res_last", 32'(res_last), 32'(e.last));
            end
            check_eq("res_cnt_pre", 32'(res_cnt), 32'(exp_cnt));
            exp_cnt = exp_cnt + CNT_W'(1);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      logic [CNT_W-1:0] cnt_before;
      int n;

      // reset state
      #1;
      check_eq("rst_res_valid", 32'(res_valid), 32'd0);
      check_eq("rst_res_data", 32'(res_data), 32'd0);
      check_eq("rst_res_cnt", 32'(res_cnt), 32'd0);
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      apply_reset();

      // 3,5,7 back to back; result visible one edge after the closing accept
      res_ready = 1'b1;
      e.sum = 6'd15; e.last = 1'b0;
      sb.push_back(e);
      send(4'd3, 1'b0);
      send(4'd5, 1'b0);
      send(4'd7, 1'b0);
      check_eq("calc_no_valid", 32'(res_valid), 32'd0);
      check_eq("calc_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check_eq("latency_valid", 32'(res_valid), 32'd1);
      check_eq("t1_data", 32'(res_data), 32'd15);
      wait_drain();
      @(posedge clk); #1;
      check_eq("t1_cnt", 32'(res_cnt), 32'd1);

      // carry-out path
      send_triple(4'd15, 4'd15, 4'd15);
      wait_drain();

      // short groups with in_last
      e.sum = 6'd9; e.last = 1'b1;
      sb.push_back(e);
      send(4'd9, 1'b1);
      check_eq("pad1_a", 32'(op_a), 32'd9);
      check_eq("pad1_b", 32'(op_b), 32'd0);
      check_eq("pad1_c", 32'(op_c), 32'd0);
      wait_drain();
      e.sum = 6'd10; e.last = 1'b1;
      sb.push_back(e);
      send(4'd4, 1'b0);
      send(4'd6, 1'b1);
      check_eq("pad2_c", 32'(op_c), 32'd0);
      wait_drain();
      e.sum = 6'd12; e.last = 1'b1;
      sb.push_back(e);
      send(4'd1, 1'b0);
      send(4'd2, 1'b0);
      send(4'd9, 1'b1);
      wait_drain();

      // backpressure: result held, extra operands ignored
      @(negedge clk);
      res_ready = 1'b0;
      send_triple(4'd1, 4'd2, 4'd3);
      n = 0;
      while (!res_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_eq("bp_valid", 32'(res_valid), 32'd1);
      cnt_before = res_cnt;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 4'd9;
         #2;
         check_eq("bp_data", 32'(res_data), 32'd6);
         check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      res_ready = 1'b1;
      @(posedge clk); #1;
      check_eq("bp_released", 32'(res_valid), 32'd0);
      check_eq("bp_cnt", 32'(res_cnt), 32'(cnt_before + CNT_W'(1)));
      check_eq("bp_op_a_clear", 32'(op_a), 32'd0);
      check_eq("bp_queue", sb.size(), 32'd0);

      // reset mid-collect discards partial operands
      send(4'd2, 1'b0);
      send(4'd2, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      check_eq("mid_rst_op_a", 32'(op_a), 32'd0);
      check_eq("mid_rst_op_b", 32'(op_b), 32'd0);
      check_eq("mid_rst_valid", 32'(res_valid), 32'd0);
      check_eq("mid_rst_data", 32'(res_data), 32'd0);
      check_eq("mid_rst_cnt", 32'(res_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send_triple(4'd1, 4'd1, 4'd1);
      wait_drain();

      // reset mid-RESULT drops the pending result at once
      @(negedge clk);
      res_ready = 1'b0;
      send_triple(4'd5, 4'd5, 4'd5);
      @(posedge clk); #1;
      check_eq("pend_valid", 32'(res_valid), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      check_eq("pend_drop", 32'(res_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      res_ready = 1'b1;

      // 257 random triples from a fresh counter: res_cnt wraps to 1
      for (int i = 0; i < 257; i++)
         send_triple(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)));
      wait_drain();
      @(posedge clk); #1;
      check_eq("wrap_cnt", 32'(res_cnt), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
